// File: rtl/eth_sw_pkg.sv
// Shared egress-path definitions: FSM states and frame length limits.
// Imported by the queue-manager egress reader.
package eth_sw_pkg;

  localparam int ETH_MAX_LEN = 1518;
  localparam int LEN_W       = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRD,
    S_PLAT,
    S_DATA,
    S_DRAIN,
    S_TAIL,
    S_IFG
  } state_e;

endpackage

// File: rtl/qm_egress_reader.sv
// Egress reader: pops a length descriptor, replays that many bytes
// from the data FIFO as a sof/dv byte stream, then inserts an IFG.
module qm_egress_reader #(
  parameter int IFG_CYCLES = 7,
  parameter int MAX_LEN    = eth_sw_pkg::ETH_MAX_LEN,
  parameter int LEN_W      = eth_sw_pkg::LEN_W
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ptr_fifo_empty,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  input  logic        tx_rdy,
  output logic        tx_sof,
  output logic        tx_dv,
  output logic [7:0]  tx_data,
  output logic [15:0] tx_frame_cnt,
  output logic [15:0] tx_drop_cnt,
  output logic        busy
);

  import eth_sw_pkg::*;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rcnt_q, rcnt_d;
  logic [7:0]       ifg_q, ifg_d;
  logic             drop_q, drop_d;
  logic             first_q, first_d;
  logic             rd_d1_q, rd_d1_d;
  logic             ptr_rd_q, ptr_rd_d;
  logic             data_rd_q, data_rd_d;
  logic             sof_q, sof_d;
  logic             dv_q, dv_d;
  logic [7:0]       data_q, data_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic [15:0]      dcnt_q, dcnt_d;

  logic [LEN_W-1:0] len;
  logic             unused_dout_hi;

  assign len            = ptr_fifo_dout[LEN_W-1:0];
  assign unused_dout_hi = ^ptr_fifo_dout[15:LEN_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      rcnt_q    <= '0;
      ifg_q     <= '0;
      drop_q    <= 1'b0;
      first_q   <= 1'b0;
      rd_d1_q   <= 1'b0;
      ptr_rd_q  <= 1'b0;
      data_rd_q <= 1'b0;
      sof_q     <= 1'b0;
      dv_q      <= 1'b0;
      data_q    <= '0;
      fcnt_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      ifg_q     <= ifg_d;
      drop_q    <= drop_d;
      first_q   <= first_d;
      rd_d1_q   <= rd_d1_d;
      ptr_rd_q  <= ptr_rd_d;
      data_rd_q <= data_rd_d;
      sof_q     <= sof_d;
      dv_q      <= dv_d;
      data_q    <= data_d;
      fcnt_q    <= fcnt_d;
      dcnt_q    <= dcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    ifg_d     = ifg_q;
    drop_d    = drop_q;
    ptr_rd_d  = 1'b0;
    data_rd_d = data_rd_q;
    fcnt_d    = fcnt_q;
    dcnt_d    = dcnt_q;
    // Output pipe runs every cycle, one stage behind the FIFO read.
    rd_d1_d   = data_rd_q;
    dv_d      = rd_d1_q & ~drop_q;
    sof_d     = rd_d1_q & first_q & ~drop_q;
    data_d    = rd_d1_q ? data_fifo_dout : 8'h00;
    first_d   = first_q & ~rd_d1_q;

    unique case (state_q)
      S_IDLE: begin
        if (!ptr_fifo_empty && tx_rdy) begin
          ptr_rd_d = 1'b1;
          state_d  = S_PRD;
        end
      end
      S_PRD: state_d = S_PLAT;
      S_PLAT: begin
        if (len == '0) begin
          state_d = S_IDLE;
        end else begin
          rcnt_d    = len;
          data_rd_d = 1'b1;
          first_d   = 1'b1;
          drop_d    = len > LEN_W'(MAX_LEN);
          state_d   = drop_d ? S_DRAIN : S_DATA;
        end
      end
      S_DATA, S_DRAIN: begin
        rcnt_d = rcnt_q - 1'b1;
        if (rcnt_q == LEN_W'(1)) begin
          data_rd_d = 1'b0;
          state_d   = S_TAIL;
        end
      end
      S_TAIL: begin
        if (!rd_d1_q) begin
          if (drop_q) dcnt_d = dcnt_q + 16'd1;
          else        fcnt_d = fcnt_q + 16'd1;
          ifg_d   = '0;
          state_d = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
        end
      end
      S_IFG: begin
        ifg_d = ifg_q + 8'd1;
        if (ifg_q == 8'(IFG_CYCLES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ptr_fifo_rd  = ptr_rd_q;
  assign data_fifo_rd = data_rd_q;
  assign tx_sof       = sof_q;
  assign tx_dv        = dv_q;
  assign tx_data      = data_q;
  assign tx_frame_cnt = fcnt_q;
  assign tx_drop_cnt  = dcnt_q;
  assign busy         = state_q != S_IDLE;

endmodule
